// File: rtl/input_debouncer.sv
// Synchroniser plus stable-time filter for a bouncy asynchronous input, with registered level and edge strobes.
// Define DEBOUNCER_GLITCH_COUNT_EN to build the saturating rejected-glitch counter on Glitch_cnt.
module input_debouncer #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1000,
  parameter int CNT_W         = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       In_raw,
  output logic       Out_level,
  output logic       Out_rise,
  output logic       Out_fall,
  output logic [7:0] Glitch_cnt
);

  localparam logic [1:0] ST_LOW   = 2'd0;
  localparam logic [1:0] CHK_HIGH = 2'd1;
  localparam logic [1:0] ST_HIGH  = 2'd2;
  localparam logic [1:0] CHK_LOW  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s_in;
  logic [1:0]             state;
  logic [CNT_W-1:0]       cnt;

  // Plain flop chain; nothing may sit between stages.
  always_ff @(posedge CLK) begin
    if (RST) sync <= '0;
    else     sync <= {sync[SYNC_STAGES-2:0], In_raw};
  end

  assign s_in = sync[SYNC_STAGES-1];

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_LOW;
      cnt       <= '0;
      Out_level <= 1'b0;
      Out_rise  <= 1'b0;
      Out_fall  <= 1'b0;
    end else begin
      Out_rise <= 1'b0;
      Out_fall <= 1'b0;
      case (state)
        ST_LOW: begin
          Out_level <= 1'b0;
          if (s_in) begin
            state <= CHK_HIGH;
            cnt   <= '0;
          end
        end
        CHK_HIGH: begin
          if (!s_in) begin
            state <= ST_LOW;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state     <= ST_HIGH;
            Out_level <= 1'b1;
            Out_rise  <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_HIGH: begin
          Out_level <= 1'b1;
          if (!s_in) begin
            state <= CHK_LOW;
            cnt   <= '0;
          end
        end
        CHK_LOW: begin
          if (s_in) begin
            state <= ST_HIGH;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state     <= ST_LOW;
            Out_level <= 1'b0;
            Out_fall  <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state     <= ST_LOW;
          cnt       <= '0;
          Out_level <= 1'b0;
        end
      endcase
    end
  end

`ifdef DEBOUNCER_GLITCH_COUNT_EN
  logic abort;

  // An abort is a check window that saw the input fall back before acceptance.
  assign abort = ((state == CHK_HIGH) && !s_in) || ((state == CHK_LOW) && s_in);

  always_ff @(posedge CLK) begin
    if (RST)                           Glitch_cnt <= 8'd0;
    else if (abort && Glitch_cnt != 8'hFF) Glitch_cnt <= Glitch_cnt + 8'd1;
  end
`else
  assign Glitch_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Randomised and directed bench for input_debouncer against a run-length reference model.
module tb_input_debouncer;
  localparam int SS = 2;
  localparam int SC = 4;
  localparam int CW = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_raw = 1'b0;
  logic       out_level, out_rise, out_fall;
  logic [7:0] glitch_cnt;

  int chk_cnt = 0;
  int err_cnt = 0;

  input_debouncer #(.SYNC_STAGES(SS), .STABLE_CYCLES(SC), .CNT_W(CW)) dut (
    .CLK(clk), .RST(rst), .In_raw(in_raw),
    .Out_level(out_level), .Out_rise(out_rise), .Out_fall(out_fall),
    .Glitch_cnt(glitch_cnt)
  );

  always #5 clk = ~clk;

  // Reference: s_in is In_raw delayed SS edges; the level flips once s_in has
  // disagreed with it for SC+1 consecutive samples, otherwise the run is a glitch.
  bit q[$];
  bit m_lvl = 1'b0, m_rise = 1'b0, m_fall = 1'b0;
  int m_run = 0, m_gc = 0;
  bit armed = 1'b0;

  always @(posedge clk) begin
    bit s;
    if (rst) begin
      q.delete();
      for (int i = 0; i < SS; i++) q.push_back(1'b0);
      m_lvl = 0; m_rise = 0; m_fall = 0; m_run = 0; m_gc = 0;
      armed = 1'b1;
    end else begin
      s = q.pop_front();
      q.push_back(in_raw);
      m_rise = 0; m_fall = 0;
      if (s != m_lvl) begin
        m_run++;
        if (m_run == SC + 1) begin
          m_lvl = s; m_run = 0;
          m_rise = s; m_fall = !s;
        end
      end else begin
        if (m_run > 0) m_gc++;
        m_run = 0;
      end
    end
  end

  function automatic int exp_gc(input int g);
`ifdef DEBOUNCER_GLITCH_COUNT_EN
    return (g > 255) ? 255 : g;
`else
    return 0;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      check("model_level", 32'(out_level), 32'(m_lvl));
      check("model_rise",  32'(out_rise),  32'(m_rise));
      check("model_fall",  32'(out_fall),  32'(m_fall));
      check("model_gcnt",  32'(glitch_cnt), 32'(exp_gc(m_gc)));
      if (out_rise === 1'b1 && out_fall === 1'b1) check("both_strobes", 32'd1, 32'd0);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Edges until Out_level equals target, bounded; timeout shows up as a failed check.
  task automatic wait_level(input logic target, input string name, output int edges);
    edges = 0;
    while (out_level !== target && edges < 40) begin
      @(negedge clk);
      edges++;
    end
    if (out_level !== target) check({name, "_timeout"}, 32'(out_level), 32'(target));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    int g0;
    // 1. Reset with input high, then full latency after release.
    in_raw = 1'b1; rst = 1'b1;
    step(2);
    check("t1_rst_level", 32'(out_level), 32'd0);
    check("t1_rst_rise",  32'(out_rise),  32'd0);
    check("t1_rst_fall",  32'(out_fall),  32'd0);
    check("t1_rst_gcnt",  32'(glitch_cnt), 32'd0);
    rst = 1'b0;
    wait_level(1'b1, "t1", e);
    check("t1_latency", 32'(e), 32'd7);
    check("t1_rise", 32'(out_rise), 32'd1);
    step(1);
    check("t1_rise_once", 32'(out_rise), 32'd0);

    // 2. Clean rise from a settled low level.
    in_raw = 1'b0;
    wait_level(1'b0, "t2_pre", e);
    step(2);
    in_raw = 1'b1;
    wait_level(1'b1, "t2", e);
    check("t2_latency", 32'(e), 32'd7);
    check("t2_rise", 32'(out_rise), 32'd1);
    check("t2_fall", 32'(out_fall), 32'd0);
    step(1);
    check("t2_rise_once", 32'(out_rise), 32'd0);

    // 3. Three-cycle glitch is rejected.
    in_raw = 1'b0;
    wait_level(1'b0, "t3_pre", e);
    step(3);
    g0 = int'(glitch_cnt);
    in_raw = 1'b1; step(3);
    in_raw = 1'b0; step(10);
    check("t3_level", 32'(out_level), 32'd0);
`ifdef DEBOUNCER_GLITCH_COUNT_EN
    check("t3_gcnt", 32'(glitch_cnt), 32'(g0 + 1));
`else
    check("t3_gcnt", 32'(glitch_cnt), 32'd0);
`endif

    // 4. Fall with a two-cycle bounce restarting the window.
    in_raw = 1'b1;
    wait_level(1'b1, "t4_pre", e);
    step(2);
    in_raw = 1'b0; step(2);
    in_raw = 1'b1; step(2);
    in_raw = 1'b0;
    wait_level(1'b0, "t4", e);
    check("t4_latency", 32'(e), 32'd7);
    check("t4_fall", 32'(out_fall), 32'd1);
    step(1);
    check("t4_fall_once", 32'(out_fall), 32'd0);

    // 5. Reset while cnt=2 in the high check window.
    step(2);
    in_raw = 1'b1;
    step(5);
    rst = 1'b1;
    step(1);
    check("t5_rst_level", 32'(out_level), 32'd0);
    check("t5_rst_rise",  32'(out_rise),  32'd0);
    check("t5_rst_gcnt",  32'(glitch_cnt), 32'd0);
    rst = 1'b0;
    wait_level(1'b1, "t5", e);
    check("t5_latency", 32'(e), 32'd7);

    // 6. Many glitches saturate the counter.
    in_raw = 1'b0;
    wait_level(1'b0, "t6_pre", e);
    step(3);
    repeat (300) begin
      in_raw = 1'b1; step(3);
      in_raw = 1'b0; step(3);
    end
    check("t6_level", 32'(out_level), 32'd0);
`ifdef DEBOUNCER_GLITCH_COUNT_EN
    check("t6_gcnt_sat", 32'(glitch_cnt), 32'd255);
`else
    check("t6_gcnt_off", 32'(glitch_cnt), 32'd0);
`endif

    // Random bursts with occasional resets, checked by the model every cycle.
    repeat (500) begin
      in_raw = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 39) == 0);
      step($urandom_range(1, 10));
    end
    rst = 1'b0;
    step(20);

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/input_debouncer.md
Name: input_debouncer

Overview:
Front-end conditioning stage for the FSM sequence detector. It takes an asynchronous, bouncy raw input (pushbutton or external pin) and synchronises it into CLK. It then filters out glitches shorter than a programmable stable time. It produces a clean level, which drives the detector's In1, plus single-cycle rise/fall strobes for other consumers.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops; legal range 2..4.
STABLE_CYCLES, 1000, cycles the synchronised input must hold a new value before it is accepted; legal range 1..2^CNT_W-1.
CNT_W, 16, width of the stability counter.

Ports:
CLK  input  1  system clock, rising edge.
RST  input  1  synchronous, active-high reset.
In_raw  input  1  raw asynchronous input; no timing relationship to CLK.
Out_level  output  1  debounced level; feeds the sequence detector's In1.
Out_rise  output  1  one-cycle strobe when Out_level goes 0->1.
Out_fall  output  1  one-cycle strobe when Out_level goes 1->0.
Glitch_cnt  output  8  count of rejected glitches; see Optional Feature.

Behaviour:
- One clock; reset is synchronous and active-high. CLK is the clock and RST is the reset.
- All outputs are registered.
- Reset (RST=1 at a rising edge):
  - synchroniser flops, counter and Glitch_cnt are cleared to 0;
  - state goes to ST_LOW;
  - Out_level, Out_rise and Out_fall are 0.
  - RST has priority over every other event, including mid-check.
- Synchroniser: In_raw passes through a SYNC_STAGES-flop chain. The last flop is s_in. No logic sits between the flops.
- State machine, four states:
  - ST_LOW: Out_level=0. If s_in=1, go to CHK_HIGH and set cnt=0. Otherwise stay.
  - CHK_HIGH: Out_level=0.
    - If s_in=0: return to ST_LOW, cnt=0, and count a glitch.
    - Else if cnt==STABLE_CYCLES-1: go to ST_HIGH, Out_level=1, Out_rise=1 for that cycle.
    - Else cnt=cnt+1.
  - ST_HIGH: Out_level=1. If s_in=0, go to CHK_LOW with cnt=0.
  - CHK_LOW: mirror of CHK_HIGH with polarity inverted.
    - s_in=1 returns to ST_HIGH and counts a glitch.
    - On acceptance: go to ST_LOW, Out_level=0, Out_fall=1.
- Strobe timing:
  - Out_rise and Out_fall assert on the same edge that Out_level changes, for exactly one cycle.
  - They are never both high.
- Latency: number the first edge that samples a new In_raw value as edge 1. Out_level changes on edge SYNC_STAGES+STABLE_CYCLES+1.
- Glitch rejection: any excursion of s_in lasting ≤ STABLE_CYCLES cycles produces no change on Out_level and no strobe.
- The counter never wraps: its maximum value is STABLE_CYCLES-1 < 2^CNT_W.
- Illegal state encodings go to ST_LOW with all outputs 0 on the next edge.
- Reset mid-check discards partial count. After RST is released, a still-asserted In_raw needs the full latency again, counted from the first post-reset edge.

Optional Feature:
Macro DEBOUNCER_GLITCH_COUNT_EN.
- Defined: Glitch_cnt increments by 1 on every CHK_HIGH->ST_LOW or CHK_LOW->ST_HIGH abort transition.
  - Saturates at 255; no wrap.
  - Cleared only by RST.
- Undefined: Glitch_cnt is tied to 8'd0 and no counter logic is built. Port list is identical in both builds.

Test Plan:
All scenarios use SYNC_STAGES=2, STABLE_CYCLES=4, CNT_W=4.
1. Reset: RST=1 for 2 edges with In_raw=1 -> Out_level/Out_rise/Out_fall/Glitch_cnt all 0. After release, Out_level=1 on the 7th edge with In_raw still 1.
2. Clean rise: In_raw 0->1 held -> Out_level=1 on edge 7. Out_rise=1 only in that cycle. Out_fall stays 0.
3. Glitch: In_raw=1 for 3 cycles then 0 -> Out_level stays 0 and no strobe. Glitch_cnt=1 with the macro, 0 without.
4. Clean fall: from Out_level=1, In_raw 1->0 held -> Out_level=0 on edge 7 with a single-cycle Out_fall. Bounce of 2 cycles high inside the window restarts the count.
5. Reset mid-check: In_raw=1; assert RST for 1 cycle once cnt=2 in CHK_HIGH -> next edge all outputs 0 and state ST_LOW. Out_level rises 7 edges after RST deasserts.
6. Saturation (macro defined): 300 three-cycle glitches -> Glitch_cnt reads 255 and stays there; Out_level remains 0 throughout.
